// File: rtl/mem_pkg.sv
// Shared types and helpers for the CPU memory responder: FSM states,
// the default MMIO address and little-endian byte/word conversion.
package mem_pkg;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'h0000_00FC;

    typedef logic [3:0][7:0] byteVec_t;

    // Lane 0 carries the lowest-addressed byte.
    function automatic logic [31:0] packLE(input byteVec_t b);
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic byteVec_t unpackLE(input logic [31:0] w);
        byteVec_t b;
        for (int i = 0; i < 4; i++) begin
            b[i] = w[8*i +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/mem_byte_lanes.sv
// Four byte-wide lane RAMs sharing one word address, with per-lane write
// enables and a registered, write-first read that holds when re_i is low.
module mem_byte_lanes
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [3:0]        we_i,
    input  logic              re_i,
    input  logic [ADDR_W-3:0] wordAddr_i,
    input  byteVec_t          wdata_i,
    output byteVec_t          rdata_o
);

    localparam int WORDS = 2 ** (ADDR_W - 2);

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] bytes_q [WORDS];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we_i[l]) begin
                bytes_q[wordAddr_i] <= wdata_i[l];
            end
            if (re_i) begin
                rd_q <= we_i[l] ? wdata_i[l] : bytes_q[wordAddr_i];
            end
        end

        assign rdata_o[l] = rd_q;
    end

endmodule

// File: rtl/mem_responder.sv
// Responder end of the multicycle CPU memory port: boot loader FSM, word
// access to the byte-lane RAM, one MMIO output register and fault pulses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] MMIO_ADDR = MMIO_ADDR_DEFAULT,
    parameter bit          BOOT_LOAD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        oob,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_ovf,
    output logic        cpu_hold,
    output logic [31:0] mmio_out
);

    localparam logic [ADDR_W:0] PTR_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   loadPtr_q, loadPtr_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       mmio_q, mmio_d;
    logic              misalign_q, oob_q;
    logic              rdZero_q;

    logic              isRun;
    logic              reqOob, reqMis, reqMmio;
    logic [3:0]        laneWe;
    logic              laneRe;
    logic [ADDR_W-3:0] laneAddr;
    byteVec_t          laneWdata, laneRdata;

    assign isRun   = (state_q == ST_RUN);
    assign reqOob  = (addr >> ADDR_W) != 32'd0;
    assign reqMis  = (addr[1:0] != 2'b00);
    assign reqMmio = !reqOob &&
                     ({{(32-ADDR_W){1'b0}}, addr[ADDR_W-1:2], 2'b00} == MMIO_ADDR);

    always_comb begin
        state_d   = state_q;
        loadPtr_d = loadPtr_q;
        ovf_d     = ovf_q;
        mmio_d    = mmio_q;
        laneWe    = 4'b0000;
        laneRe    = 1'b0;
        laneAddr  = addr[ADDR_W-1:2];
        laneWdata = unpackLE(wdata);
        case (state_q)
            ST_LOAD: begin
                if (ld_valid) begin
                    if (loadPtr_q != PTR_FULL) begin
                        laneWe    = 4'b0001 << loadPtr_q[1:0];
                        laneAddr  = loadPtr_q[ADDR_W-1:2];
                        laneWdata = {4{ld_data}};
                        loadPtr_d = loadPtr_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                laneRe = 1'b1;
                if (wr && !reqOob) begin
                    laneWe = 4'b1111;
                    if (reqMmio) begin
                        mmio_d = wdata;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // rdZero_q masks the lane output after reset and for out-of-bounds
    // requests; it only moves in RUN so rdata holds while loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT_LOAD ? ST_LOAD : ST_RUN;
            loadPtr_q  <= '0;
            ovf_q      <= 1'b0;
            mmio_q     <= 32'd0;
            misalign_q <= 1'b0;
            oob_q      <= 1'b0;
            rdZero_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            loadPtr_q  <= loadPtr_d;
            ovf_q      <= ovf_d;
            mmio_q     <= mmio_d;
            misalign_q <= isRun && reqMis;
            oob_q      <= isRun && reqOob;
            if (isRun) begin
                rdZero_q <= reqOob;
            end
        end
    end

    mem_byte_lanes #(
        .ADDR_W(ADDR_W)
    ) u_lanes (
        .clk       (clk),
        .we_i      (laneWe),
        .re_i      (laneRe),
        .wordAddr_i(laneAddr),
        .wdata_i   (laneWdata),
        .rdata_o   (laneRdata)
    );

    assign rdata    = rdZero_q ? 32'd0 : packLE(laneRdata);
    assign misalign = misalign_q;
    assign oob      = oob_q;
    assign ld_ready = !isRun;
    assign cpu_hold = !isRun;
    assign ld_ovf   = ovf_q;
    assign mmio_out = mmio_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus a random
// CPU traffic phase, all compared against a byte-array memory model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        misalign;
    logic        oob;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_ovf;
    logic        cpu_hold;
    logic [31:0] mmio_out;

    int nChecks = 0;
    int nFails  = 0;

    logic [7:0]  modelMem [256];
    bit          modelWr  [256];
    int          modelPtr;
    bit          modelOvf;
    logic [31:0] modelMmio;

    mem_responder dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wr      (wr),
        .wdata   (wdata),
        .rdata   (rdata),
        .misalign(misalign),
        .oob     (oob),
        .ld_valid(ld_valid),
        .ld_data (ld_data),
        .ld_last (ld_last),
        .ld_ready(ld_ready),
        .ld_ovf  (ld_ovf),
        .cpu_hold(cpu_hold),
        .mmio_out(mmio_out)
    );

    always #5 clk = ~clk;

    function automatic int wordBase(input logic [31:0] a);
        return int'(a[7:2]) * 4;
    endfunction

    function automatic bit modelKnown(input logic [31:0] a);
        int b = wordBase(a);
        return modelWr[b] && modelWr[b+1] && modelWr[b+2] && modelWr[b+3];
    endfunction

    function automatic logic [31:0] modelWord(input logic [31:0] a);
        int b = wordBase(a);
        return {modelMem[b+3], modelMem[b+2], modelMem[b+1], modelMem[b]};
    endfunction

    task automatic modelReset();
        modelPtr  = 0;
        modelOvf  = 1'b0;
        modelMmio = 32'd0;
    endtask

    task automatic modelCpu(input bit w, input logic [31:0] a, input logic [31:0] d);
        int b = wordBase(a);
        if (w && a < 32'd256) begin
            for (int i = 0; i < 4; i++) begin
                modelMem[b+i] = d[8*i +: 8];
                modelWr[b+i]  = 1'b1;
            end
            if (b == 252) modelMmio = d;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpuOp(input bit w, input logic [31:0] a, input logic [31:0] d);
        wr = w;
        addr = a;
        wdata = d;
        cycle();
        modelCpu(w, a, d);
    endtask

    task automatic loadByte(input logic [7:0] b, input bit last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        cycle();
        if (modelPtr < 256) begin
            modelMem[modelPtr] = b;
            modelWr[modelPtr]  = 1'b1;
            modelPtr++;
        end else begin
            modelOvf = 1'b1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        modelReset();
        nChecks++; if (rdata !== 32'd0) begin nFails++; $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 32'd0); end
        nChecks++; if (misalign !== 1'b0) begin nFails++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign); end
        nChecks++; if (oob !== 1'b0) begin nFails++; $display("[TB] FAIL reset_oob: got %b expected 0", oob); end
        nChecks++; if (ld_ovf !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ld_ovf: got %b expected 0", ld_ovf); end
        nChecks++; if (mmio_out !== 32'd0) begin nFails++; $display("[TB] FAIL reset_mmio: got %h expected 0", mmio_out); end
        nChecks++; if (ld_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_ld_ready: got %b expected 1", ld_ready); end
        nChecks++; if (cpu_hold !== 1'b1) begin nFails++; $display("[TB] FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
        rst = 1'b0;
    endtask

    task automatic test_load();
        logic [7:0] img [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        addr = 32'h9;
        wr   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            loadByte(img[i], i == 3);
            if (i < 3) begin
                nChecks++; if (cpu_hold !== 1'b1) begin nFails++; $display("[TB] FAIL load_hold_%0d: got %b expected 1", i, cpu_hold); end
            end
            nChecks++; if (misalign !== 1'b0) begin nFails++; $display("[TB] FAIL load_ignores_cpu_%0d: got %b expected 0", i, misalign); end
        end
        nChecks++; if (cpu_hold !== 1'b0) begin nFails++; $display("[TB] FAIL load_hold_release: got %b expected 0", cpu_hold); end
        nChecks++; if (ld_ready !== 1'b0) begin nFails++; $display("[TB] FAIL load_ready_drop: got %b expected 0", ld_ready); end
        nChecks++; if (rdata !== 32'd0) begin nFails++; $display("[TB] FAIL load_rdata_hold: got %h expected 0", rdata); end
        cpuOp(1'b0, 32'h0, 32'h0);
        nChecks++; if (rdata !== 32'h04030201) begin nFails++; $display("[TB] FAIL load_readback: got %h expected %h", rdata, 32'h04030201); end
    endtask

    task automatic test_run_rw();
        cpuOp(1'b1, 32'h8, 32'hDEADBEEF);
        nChecks++; if (rdata !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL rw_write_first: got %h expected DEADBEEF", rdata); end
        cpuOp(1'b0, 32'h8, 32'h0);
        nChecks++; if (rdata !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL rw_readback: got %h expected DEADBEEF", rdata); end
        nChecks++; if (misalign !== 1'b0) begin nFails++; $display("[TB] FAIL rw_aligned_flag: got %b expected 0", misalign); end
        cpuOp(1'b0, 32'h9, 32'h0);
        nChecks++; if (rdata !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL rw_misaligned_read: got %h expected DEADBEEF", rdata); end
        nChecks++; if (misalign !== 1'b1) begin nFails++; $display("[TB] FAIL rw_misalign_pulse: got %b expected 1", misalign); end
        cpuOp(1'b0, 32'h8, 32'h0);
        nChecks++; if (misalign !== 1'b0) begin nFails++; $display("[TB] FAIL rw_misalign_one_cycle: got %b expected 0", misalign); end
    endtask

    task automatic test_oob();
        logic [31:0] mmioBefore = modelMmio;
        cpuOp(1'b1, 32'h100, 32'h12345678);
        nChecks++; if (oob !== 1'b1) begin nFails++; $display("[TB] FAIL oob_write_pulse: got %b expected 1", oob); end
        nChecks++; if (mmio_out !== mmioBefore) begin nFails++; $display("[TB] FAIL oob_mmio_kept: got %h expected %h", mmio_out, mmioBefore); end
        cpuOp(1'b0, 32'h100, 32'h0);
        nChecks++; if (rdata !== 32'd0) begin nFails++; $display("[TB] FAIL oob_read_zero: got %h expected 0", rdata); end
        nChecks++; if (oob !== 1'b1) begin nFails++; $display("[TB] FAIL oob_read_pulse: got %b expected 1", oob); end
        cpuOp(1'b0, 32'h0, 32'h0);
        nChecks++; if (rdata !== 32'h04030201) begin nFails++; $display("[TB] FAIL oob_ram_kept: got %h expected 04030201", rdata); end
        nChecks++; if (oob !== 1'b0) begin nFails++; $display("[TB] FAIL oob_clears: got %b expected 0", oob); end
        cpuOp(1'b0, 32'h8000_0103, 32'h0);
        nChecks++; if ({oob, misalign} !== 2'b11) begin nFails++; $display("[TB] FAIL oob_and_misalign: got %b expected 11", {oob, misalign}); end
        nChecks++; if (rdata !== 32'd0) begin nFails++; $display("[TB] FAIL oob_misaligned_zero: got %h expected 0", rdata); end
    endtask

    task automatic test_mmio();
        cpuOp(1'b1, 32'hFC, 32'hA5A5A5A5);
        nChecks++; if (mmio_out !== 32'hA5A5A5A5) begin nFails++; $display("[TB] FAIL mmio_update: got %h expected A5A5A5A5", mmio_out); end
        cpuOp(1'b0, 32'hFC, 32'h0);
        nChecks++; if (rdata !== 32'hA5A5A5A5) begin nFails++; $display("[TB] FAIL mmio_readback: got %h expected A5A5A5A5", rdata); end
        cpuOp(1'b1, 32'hF8, 32'h0BADF00D);
        nChecks++; if (mmio_out !== 32'hA5A5A5A5) begin nFails++; $display("[TB] FAIL mmio_other_addr: got %h expected A5A5A5A5", mmio_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int          kind = $urandom_range(0, 9);
            bit          w    = $urandom_range(0, 1) == 1;
            logic [31:0] d    = $urandom;
            logic [31:0] a;
            logic [31:0] expW;
            bit          known;
            bit          isOob;
            if (kind == 0)      a = 32'hFC | 32'($urandom_range(0, 3));
            else if (kind < 6)  a = {24'd0, 6'($urandom_range(0, 15)), 2'b00};
            else if (kind < 8)  a = 32'($urandom_range(0, 255));
            else begin
                a = $urandom;
                if (a < 32'd256) a = a | 32'h100;
            end
            isOob = a >= 32'd256;
            known = modelKnown(a);
            expW  = modelWord(a);
            cpuOp(w, a, d);
            nChecks++; if (misalign !== (a[1:0] != 2'b00)) begin nFails++; $display("[TB] FAIL rand_misalign[%0d] addr %h: got %b expected %b", i, a, misalign, a[1:0] != 2'b00); end
            nChecks++; if (oob !== isOob) begin nFails++; $display("[TB] FAIL rand_oob[%0d] addr %h: got %b expected %b", i, a, oob, isOob); end
            nChecks++; if (mmio_out !== modelMmio) begin nFails++; $display("[TB] FAIL rand_mmio[%0d] addr %h: got %h expected %h", i, a, mmio_out, modelMmio); end
            if (isOob && !w) begin
                nChecks++; if (rdata !== 32'd0) begin nFails++; $display("[TB] FAIL rand_oob_read[%0d] addr %h: got %h expected 0", i, a, rdata); end
            end else if (!isOob && w) begin
                nChecks++; if (rdata !== d) begin nFails++; $display("[TB] FAIL rand_write_first[%0d] addr %h: got %h expected %h", i, a, rdata, d); end
            end else if (!isOob && known) begin
                nChecks++; if (rdata !== expW) begin nFails++; $display("[TB] FAIL rand_read[%0d] addr %h: got %h expected %h", i, a, rdata, expW); end
            end
        end
    endtask

    task automatic test_overflow_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        modelReset();
        wr    = 1'b1;
        addr  = 32'h9;
        wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 257; i++) begin
            logic [7:0] b = 8'(i) ^ 8'h5A;
            loadByte(b, 1'b0);
            if (i == 255) begin
                nChecks++; if (ld_ovf !== 1'b0) begin nFails++; $display("[TB] FAIL ovf_not_early: got %b expected 0", ld_ovf); end
            end
        end
        nChecks++; if (ld_ovf !== modelOvf) begin nFails++; $display("[TB] FAIL ovf_set: got %b expected %b", ld_ovf, modelOvf); end
        cycle();
        nChecks++; if (ld_ovf !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_sticky: got %b expected 1", ld_ovf); end
        nChecks++; if (cpu_hold !== 1'b1) begin nFails++; $display("[TB] FAIL ovf_still_loading: got %b expected 1", cpu_hold); end
        nChecks++; if ({misalign, rdata} !== 33'd0) begin nFails++; $display("[TB] FAIL ovf_cpu_ignored: got %b/%h expected 0/0", misalign, rdata); end
        wr = 1'b0;

        loadByte(8'hAA, 1'b0);
        loadByte(8'hBB, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        modelReset();
        nChecks++; if (ld_ovf !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_ovf: got %b expected 0", ld_ovf); end
        nChecks++; if (ld_ready !== 1'b1 || cpu_hold !== 1'b1) begin nFails++; $display("[TB] FAIL midreset_state: got ready %b hold %b expected 1 1", ld_ready, cpu_hold); end
        nChecks++; if ({rdata, mmio_out, misalign, oob} !== 66'd0) begin nFails++; $display("[TB] FAIL midreset_outputs: got %h %h %b %b expected zeros", rdata, mmio_out, misalign, oob); end

        loadByte(8'h11, 1'b0);
        loadByte(8'h22, 1'b0);
        loadByte(8'h33, 1'b0);
        loadByte(8'h44, 1'b1);
        nChecks++; if (cpu_hold !== 1'b0) begin nFails++; $display("[TB] FAIL reload_run: got %b expected 0", cpu_hold); end
        cpuOp(1'b0, 32'h0, 32'h0);
        nChecks++; if (rdata !== 32'h44332211) begin nFails++; $display("[TB] FAIL reload_ptr_restart: got %h expected 44332211", rdata); end
        cpuOp(1'b0, 32'h4, 32'h0);
        nChecks++; if (rdata !== modelWord(32'h4)) begin nFails++; $display("[TB] FAIL reload_image_kept: got %h expected %h", rdata, modelWord(32'h4)); end
    endtask

    initial begin
        rst      = 1'b1;
        addr     = 32'd0;
        wr       = 1'b0;
        wdata    = 32'd0;
        ld_valid = 1'b0;
        ld_data  = 8'd0;
        ld_last  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            modelMem[i] = 8'd0;
            modelWr[i]  = 1'b0;
        end
        modelReset();

        test_reset();
        test_load();
        test_run_rw();
        test_oob();
        test_mmio();
        test_random();
        test_overflow_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
